// File: rtl/seq_mult_8bits_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier:
// FSM state encoding and iteration count.
package seq_mult_8bits_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MULT_ITERS = 8;
    localparam int FA_WIDTH   = 8;

endpackage

// File: rtl/fa_8bits.sv
// 8-bit adder with carry in/out; the multiplier's only arithmetic element.
module fa_8bits (
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    input  logic       cin,
    output logic       cout,
    output logic [7:0] sum
);

    assign {cout, sum} = {1'b0, i0} + {1'b0, i1} + {8'd0, cin};

endmodule

// File: rtl/seq_mult_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/busy/done
// handshake; one partial-sum addition per cycle through fa_8bits.
//
// state  | meaning
// IDLE   | waiting for start; product holds the last result
// RUN    | 8 shift-and-add iterations on {A,Q}
// DONE   | done pulse, product valid; a held start is accepted on exit
module seq_mult_8bits
    import seq_mult_8bits_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_ITERS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   fa_sum;
    logic               fa_cout;
    logic [WIDTH:0]     part;

    fa_8bits u_fa (
        .i0   (acc_q),
        .i1   (m_q),
        .cin  (1'b0),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // 9-bit partial sum {C, A'}; the carry becomes the new MSB of A on the shift
    always_comb begin
        part = {1'b0, acc_q};
        if (q_q[0]) begin
            part = {fa_cout, fa_sum};
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            // Leaving DONE is the same edge as entering IDLE, so a held start
            // restarts here and keeps the 9-cycle cadence.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = part[WIDTH:1];
                q_d   = {part[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = {acc_d, q_d};
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8bits.sv
// Self-checking bench for seq_mult_8bits: scoreboard of expected products,
// latency, busy rejection, abort and back-to-back cadence.
module tb_seq_mult_8bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          n_cmp;
    int          n_err;
    logic [15:0] sb_q[$];
    logic [15:0] last_prod;

    seq_mult_8bits dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < budget && !seen) begin
            tick();
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_one_op(input logic [7:0] av, input logic [7:0] bv);
        logic [15:0] exp_v;
        logic [15:0] got;
        int          cyc;
        bit          seen;
        exp_v  = 16'(av) * 16'(bv);
        sb_q.push_back(exp_v);
        a_in   = av;
        b_in   = bv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a_in   = 8'($urandom);
        b_in   = 8'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL op_busy %0d*%0d: busy=%b required 1", av, bv, busy);
        end
        n_cmp++;
        if (product !== last_prod) begin
            n_err++;
            $display("FAIL op_hold %0d*%0d: product=%0d required %0d", av, bv, product, last_prod);
        end
        wait_done(20, cyc, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL op_timeout %0d*%0d: no done within 20 cycles", av, bv);
        end else if (cyc != 8) begin
            n_err++;
            $display("FAIL op_latency %0d*%0d: latency=%0d required 8", av, bv, cyc);
        end
        if (seen) begin
            got = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (product !== got) begin
                n_err++;
                $display("FAIL op_product %0d*%0d: product=%0d required %0d", av, bv, product, got);
            end
            last_prod = got;
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL op_after %0d*%0d: busy=%b done=%b required 0 0", av, bv, busy, done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            n_err++;
            $display("FAIL reset_init: busy=%b done=%b product=%0d required 0 0 0", busy, done, product);
        end
        last_prod = 16'd0;
        test_one_op(8'd13, 8'd11);
        a_in  = 8'd6;
        b_in  = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #4;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            n_err++;
            $display("FAIL reset_async: busy=%b done=%b product=%0d required 0 0 0", busy, done, product);
        end
        #20;
        tick();
        rst = 1'b0;
        last_prod = 16'd0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b done=%b product=%0d required 0 0 0", busy, done, product);
        end
    endtask

    task automatic test_basic();
        test_one_op(8'd29, 8'd5);
    endtask

    task automatic test_values();
        test_one_op(8'd255, 8'd255);
        test_one_op(8'd0, 8'd200);
        test_one_op(8'd200, 8'd95);
        test_one_op(8'd1, 8'd255);
        test_one_op(8'd128, 8'd2);
    endtask

    task automatic test_busy_reject();
        logic [15:0] got;
        int          cyc;
        bit          seen;
        int          n_done;
        sb_q.push_back(16'd4692);
        a_in  = 8'd51;
        b_in  = 8'd92;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in  = 8'd17;
        b_in  = 8'd28;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, cyc, seen);
        n_cmp++;
        if (!seen || cyc + 3 != 8) begin
            n_err++;
            $display("FAIL reject_latency: seen=%b latency=%0d required 1 8", seen, cyc + 3);
        end
        got = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (product !== got) begin
            n_err++;
            $display("FAIL reject_product: product=%0d required %0d", product, got);
        end
        last_prod = got;
        n_done = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0 || busy !== 1'b0 || product !== last_prod) begin
            n_err++;
            $display("FAIL reject_single: extra_done=%0d busy=%b product=%0d required 0 0 %0d",
                     n_done, busy, product, last_prod);
        end
    endtask

    task automatic test_abort();
        int n_done;
        n_done = 0;
        a_in   = 8'd191;
        b_in   = 8'd2;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        #4;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (n_done != 0 || busy !== 1'b0 || product !== 16'd0) begin
            n_err++;
            $display("FAIL abort_state: done_pulses=%0d busy=%b product=%0d required 0 0 0",
                     n_done, busy, product);
        end
        tick();
        rst = 1'b0;
        last_prod = 16'd0;
        tick();
        test_one_op(8'd78, 8'd255);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  av[4];
        logic [7:0]  bv[4];
        logic [15:0] got;
        int          cyc;
        int          last_cyc;
        int          ops;
        av[0] = 8'd12;  bv[0] = 8'd34;
        av[1] = 8'd255; bv[1] = 8'd1;
        av[2] = 8'd99;  bv[2] = 8'd201;
        av[3] = 8'd7;   bv[3] = 8'd0;
        a_in  = av[0];
        b_in  = bv[0];
        sb_q.push_back(16'(av[0]) * 16'(bv[0]));
        start    = 1'b1;
        cyc      = 0;
        last_cyc = 0;
        ops      = 0;
        tick();
        while (cyc < 60 && ops < 4) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                got = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                n_cmp++;
                if (product !== got) begin
                    n_err++;
                    $display("FAIL b2b_product op%0d: product=%0d required %0d", ops, product, got);
                end
                n_cmp++;
                if (cyc - last_cyc != ((ops == 0) ? 8 : 9)) begin
                    n_err++;
                    $display("FAIL b2b_spacing op%0d: spacing=%0d required %0d",
                             ops, cyc - last_cyc, (ops == 0) ? 8 : 9);
                end
                last_cyc = cyc;
                last_prod = got;
                ops++;
                if (ops < 4) begin
                    a_in = av[ops];
                    b_in = bv[ops];
                    sb_q.push_back(16'(av[ops]) * 16'(bv[ops]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ops != 4) begin
            n_err++;
            $display("FAIL b2b_count: completed=%0d required 4", ops);
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b pending=%0d required 0 0", busy, sb_q.size());
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_prod = 16'd0;
        test_reset();
        test_basic();
        test_values();
        test_busy_reject();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
